// File: rtl/psum_sram_writer_pkg.sv
// Shared constants and state encoding for the psum SRAM write path.
// The output SRAM is 32b x 2048; a psum vector is COL columns of PSUM_BW bits.
package psum_sram_writer_pkg;

    localparam int PSUM_BW      = 16;
    localparam int COL          = 8;
    localparam int SRAM_BW      = 32;
    localparam int SRAM_ADDR_BW = 11;
    localparam int VEC_BW       = COL * PSUM_BW;
    localparam int WPV          = VEC_BW / SRAM_BW;
    localparam int BEAT_BW      = $clog2(WPV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/psum_sram_writer_if.sv
// Psum vector stream from the corelet into the SRAM writer (valid/ready).
interface psum_sram_writer_if;
    import psum_sram_writer_pkg::*;

    logic              in_valid;
    logic [VEC_BW-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/psum_serializer.sv
// Holds one psum vector and hands it out one SRAM word per beat, word 0 first.
// The low word of the shift register is the SRAM data output, so it is a plain
// register and keeps its value once the last word has been presented.
module psum_serializer
    import psum_sram_writer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [VEC_BW-1:0]  vec,
    output logic [SRAM_BW-1:0] word,
    output logic               last_beat
);

    localparam logic [BEAT_BW-1:0] LAST_BEAT = BEAT_BW'(WPV - 1);

    logic [VEC_BW-1:0]  sreg_r;
    logic [BEAT_BW-1:0] beat_r;

    // Load a fresh vector on handshake, otherwise step to the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_r <= {VEC_BW{1'b0}};
            beat_r <= {BEAT_BW{1'b0}};
        end else if (load) begin
            sreg_r <= vec;
            beat_r <= {BEAT_BW{1'b0}};
        end else if (shift) begin
            sreg_r <= {{SRAM_BW{1'b0}}, sreg_r[VEC_BW-1:SRAM_BW]};
            beat_r <= beat_r + {{(BEAT_BW-1){1'b0}}, 1'b1};
        end else begin
            sreg_r <= sreg_r;
            beat_r <= beat_r;
        end
    end

    assign word      = sreg_r[SRAM_BW-1:0];
    assign last_beat = (beat_r == LAST_BEAT);

endmodule

// File: rtl/psum_sram_writer.sv
// Write-side initiator for the output SRAM: takes psum vectors from the corelet,
// slices them into 32b words and writes them to consecutive addresses from a
// programmable base. While the last word of a vector is written the next vector
// can already be accepted, so a held in_valid gives one word every cycle.
module psum_sram_writer
    import psum_sram_writer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SRAM_ADDR_BW-1:0] base_addr,
    input  logic [SRAM_ADDR_BW-1:0] num_vec,
    output logic                    busy,
    output logic                    done,
    psum_sram_writer_if.slave       in_if,
    output logic                    sram_cen,
    output logic                    sram_wen,
    output logic [SRAM_ADDR_BW-1:0] sram_a,
    output logic [SRAM_BW-1:0]      sram_d
);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [SRAM_ADDR_BW-1:0] num_vec_r;
    logic [SRAM_ADDR_BW-1:0] vec_cnt_r;
    logic [SRAM_ADDR_BW-1:0] next_addr_r;
    logic [SRAM_ADDR_BW-1:0] addr_r;
    logic [SRAM_ADDR_BW:0]   vec_inc_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    cen_r;
    logic                    more_s;
    logic                    in_ready_s;
    logic                    hs_s;
    logic                    issue_s;
    logic                    load_s;
    logic                    shift_s;
    logic                    last_beat_s;
    logic [SRAM_BW-1:0]      word_s;

    psum_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .shift     (shift_s),
        .vec       (in_if.in_data),
        .word      (word_s),
        .last_beat (last_beat_s)
    );

    // Another vector is still owed after the one currently being written.
    assign vec_inc_s = {1'b0, vec_cnt_r} + {{SRAM_ADDR_BW{1'b0}}, 1'b1};
    assign more_s    = (vec_inc_s < {1'b0, num_vec_r});

    // Ready while waiting, or on the final beat when another vector is owed.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == WAIT) begin
            in_ready_s = 1'b1;
        end else if ((state_r == WRITE) && last_beat_s && more_s) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign hs_s           = in_if.in_valid && in_ready_s;
    assign in_if.in_ready = in_ready_s;

    // Next-state and beat control: each issued beat is one SRAM write next cycle.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (num_vec == {SRAM_ADDR_BW{1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (hs_s) begin
                    state_nxt_s = WRITE;
                    load_s      = 1'b1;
                    issue_s     = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WRITE: begin
                if (last_beat_s) begin
                    if (!more_s) begin
                        state_nxt_s = DONE;
                    end else if (hs_s) begin
                        state_nxt_s = WRITE;
                        load_s      = 1'b1;
                        issue_s     = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = WRITE;
                    shift_s     = 1'b1;
                    issue_s     = 1'b1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus the status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == WAIT) || (state_nxt_s == WRITE);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Job parameters and vector count; a start outside IDLE is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_vec_r <= {SRAM_ADDR_BW{1'b0}};
            vec_cnt_r <= {SRAM_ADDR_BW{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            num_vec_r <= num_vec;
            vec_cnt_r <= {SRAM_ADDR_BW{1'b0}};
        end else if ((state_r == WRITE) && last_beat_s) begin
            num_vec_r <= num_vec_r;
            vec_cnt_r <= vec_cnt_r + {{(SRAM_ADDR_BW-1){1'b0}}, 1'b1};
        end else begin
            num_vec_r <= num_vec_r;
            vec_cnt_r <= vec_cnt_r;
        end
    end

    // Running address; wraps naturally at the top of the SRAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_addr_r <= {SRAM_ADDR_BW{1'b0}};
            addr_r      <= {SRAM_ADDR_BW{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            next_addr_r <= base_addr;
            addr_r      <= addr_r;
        end else if (issue_s) begin
            next_addr_r <= next_addr_r + {{(SRAM_ADDR_BW-1){1'b0}}, 1'b1};
            addr_r      <= next_addr_r;
        end else begin
            next_addr_r <= next_addr_r;
            addr_r      <= addr_r;
        end
    end

    // Chip/write enable: both low only for an issued beat, never a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            cen_r <= 1'b1;
        end else begin
            cen_r <= ~issue_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sram_cen = cen_r;
    assign sram_wen = cen_r;
    assign sram_a   = addr_r;
    assign sram_d   = word_s;

endmodule
